// File: rtl/timetag_pkg.sv
// Shared types and defaults for the FX2 slave-FIFO byte writer.
package timetag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } wr_state_e;

  localparam int unsigned PKT_BYTES_DEF    = 512;
  localparam int unsigned IDLE_TIMEOUT_DEF = 4096;
  localparam int unsigned TMR_W            = 16;

endpackage

// File: rtl/commit_timer.sv
// Idle timer that flags when a partial packet has sat unwritten long enough to commit.
module commit_timer
  import timetag_pkg::*;
#(
  parameter int unsigned TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  input  logic run,
  input  logic busy,
  output logic expire
);

  localparam logic [TMR_W-1:0] RELOAD_VAL = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] ONE        = TMR_W'(1);

  logic [TMR_W-1:0] idle_tmr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_tmr <= RELOAD_VAL;
    end else if (reload) begin
      idle_tmr <= RELOAD_VAL;
    end else if (run && idle_tmr != '0) begin
      idle_tmr <= idle_tmr - ONE;
    end
  end

  // A byte being loaded or held this cycle beats the expiry; the pending write reloads the timer.
  assign expire = run & ~reload & ~busy & (idle_tmr == ONE);

endmodule

// File: rtl/fx2_byte_writer.sv
// Streams upstream bytes into an FX2 slave FIFO and commits short packets after an idle gap.
module fx2_byte_writer
  import timetag_pkg::*;
#(
  parameter int unsigned PKT_BYTES    = PKT_BYTES_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       data_rdy,
  output logic       data_ack,
  input  logic       fifo_full_n,
  output logic [7:0] fd,
  output logic       slwr_n,
  output logic       pktend_n
);

  localparam int unsigned      CNT_W    = $clog2(PKT_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  wr_state_e        state, state_nxt;
  logic [7:0]       hold_data;
  logic             hold_valid;
  logic [CNT_W-1:0] byte_cnt;
  logic             drain, load, cnt_wrap, expire, pkt_fire;

  assign drain    = hold_valid & fifo_full_n & (state != COMMIT);
  assign load     = reset_n & data_rdy & (~hold_valid | drain);
  assign data_ack = load;
  assign cnt_wrap = drain & (byte_cnt == CNT_LAST);

  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_data  <= data;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fd       <= 8'h00;
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
    end else begin
      slwr_n   <= ~drain;
      pktend_n <= ~pkt_fire;
      if (drain) fd <= hold_data;
    end
  end

  // Power-of-two packet size: the counter wraps on its own with no pktend.
  always_ff @(posedge clk) begin
    if (!reset_n)      byte_cnt <= '0;
    else if (pkt_fire) byte_cnt <= '0;
    else if (drain)    byte_cnt <= byte_cnt + CNT_ONE;
  end

  commit_timer #(.TIMEOUT(IDLE_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .reload  (drain),
    .run     (byte_cnt != '0),
    .busy    (hold_valid | load),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default the combinational outputs first so no path leaves them unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain) state_nxt = FILL;
      FILL: begin
        if (cnt_wrap)    state_nxt = IDLE;
        else if (expire) state_nxt = COMMIT;
      end
      COMMIT:  if (fifo_full_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_fire = 1'b0;
    if (state == COMMIT && fifo_full_n) pkt_fire = 1'b1;
  end

endmodule

// File: tb/tb_fx2_byte_writer.sv
// Scoreboard bench for fx2_byte_writer: upstream bytes are queued on ack and matched against FX2 writes.
module tb_fx2_byte_writer;
  import timetag_pkg::*;

  localparam int unsigned PKT = 512;
  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_rdy = 1'b0;
  logic       data_ack;
  logic       fifo_full_n = 1'b1;
  logic [7:0] fd;
  logic       slwr_n, pktend_n;

  fx2_byte_writer #(.PKT_BYTES(PKT), .IDLE_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data        (data),
    .data_rdy    (data_rdy),
    .data_ack    (data_ack),
    .fifo_full_n (fifo_full_n),
    .fd          (fd),
    .slwr_n      (slwr_n),
    .pktend_n    (pktend_n)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int ack_cyc_q[$];
  int wr_cyc_q[$];
  int rdy_pct = 100;
  bit ff_rand = 0, lat_check = 0, pkt_allowed = 0, acked_now = 0;
  int n_acked = 0, n_written = 0, n_pktend = 0;
  int last_wr_cyc = 0, last_pkt_cyc = 0;
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Upstream source: holds a byte on data/data_rdy until it is acked.
  initial begin : upstream
    forever begin
      @(posedge clk); #1;
      if (acked_now) data_rdy = 1'b0;
      if (!data_rdy && src_q.size() > 0 && $urandom_range(0, 99) < rdy_pct) begin
        data     = src_q.pop_front();
        data_rdy = 1'b1;
      end
    end
  end

  initial begin : ff_driver
    forever begin
      @(posedge clk); #1;
      if (ff_rand) fifo_full_n = ($urandom_range(0, 99) < 70);
    end
  end

  // Monitor: every FX2 write must match the oldest acked byte still owed.
  initial begin : monitor
    logic [7:0] e;
    int a;
    forever begin
      @(negedge clk);
      if (!slwr_n || !pktend_n) check("strobe_exclusive", {31'd0, slwr_n | pktend_n}, 1);
      if (!slwr_n) begin
        n_written++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
        model_cnt = (model_cnt + 1) % PKT;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got fd=0x%0h expected no write at cycle %0d", fd, cyc);
        end else begin
          e = exp_q.pop_front();
          a = ack_cyc_q.pop_front();
          check("fd_data", fd, e);
          if (lat_check) check("write_latency", cyc - a, 2);
        end
      end
      if (!pktend_n) begin
        n_pktend++;
        last_pkt_cyc = cyc;
        model_cnt = 0;
        if (!pkt_allowed) begin
          checks++; errors++;
          $display("FAIL unexpected_pktend: got pktend_n=0 expected 1 at cycle %0d", cyc);
        end
      end
      if (!reset_n) begin
        exp_q.delete();
        ack_cyc_q.delete();
        model_cnt = 0;
      end
      acked_now = data_ack;
      if (data_ack) begin
        exp_q.push_back(data);
        ack_cyc_q.push_back(cyc);
        n_acked++;
      end
    end
  end

  task automatic wait_written(input int target, input int budget, input string name);
    int k = 0;
    while (n_written < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, {31'd0, n_written >= target}, 1);
  endtask

  task automatic wait_acked(input int target, input int budget, input string name);
    int k = 0;
    while (n_acked < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, {31'd0, n_acked >= target}, 1);
  endtask

  // Waits for the next pktend pulse and checks it came IDLE_TIMEOUT+1 cycles after the last write.
  task automatic wait_pktend(input string name);
    int k = 0;
    int p0 = n_pktend;
    while (n_pktend == p0 && k < 4 * TMO + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_seen"}, {31'd0, n_pktend == p0 + 1}, 1);
    check({name, "_delay"}, last_pkt_cyc - last_wr_cyc, TMO + 1);
    @(negedge clk);
    check({name, "_one_cycle"}, {31'd0, pktend_n}, 1);
    check({name, "_byte_cnt"}, dut.byte_cnt, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_until_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_seq(input int n);
    for (int i = 1; i <= n; i++) src_q.push_back(8'(i));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int w0, a0, p0, l0;
    // Reset with a byte already offered: no ack, outputs at reset values.
    src_q.push_back(8'hAA);
    repeat (3) begin
      @(negedge clk);
      check("reset_data_ack", {31'd0, data_ack}, 0);
      check("reset_slwr_n", {31'd0, slwr_n}, 1);
      check("reset_pktend_n", {31'd0, pktend_n}, 1);
      check("reset_fd", fd, 0);
    end
    check("reset_rdy_offered", {31'd0, data_rdy}, 1);
    check("reset_hold_valid", {31'd0, dut.hold_valid}, 0);
    check("reset_byte_cnt", dut.byte_cnt, 0);
    check("reset_idle_tmr", dut.u_timer.idle_tmr, TMO);
    check("reset_state", dut.state, IDLE);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pkt_allowed = 1;
    wait_written(1, 20, "warmup_written");
    wait_pktend("warmup_pktend");

    // Six bytes at full rate: latency 2, consecutive strobes, then timeout commit.
    lat_check = 1;
    w0 = n_written;
    push_seq(6);
    wait_written(w0 + 6, 40, "seq6_written");
    check("seq6_consecutive", wr_cyc_q[w0 + 5] - wr_cyc_q[w0], 5);
    check("seq6_byte_cnt", dut.byte_cnt, model_cnt);
    wait_pktend("seq6_pktend");
    lat_check = 0;

    // FIFO full for 10 cycles after byte 03 is acked.
    w0 = n_written;
    a0 = n_acked;
    push_seq(6);
    wait_acked(a0 + 3, 40, "stall_ack3");
    fifo_full_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data_ack", {31'd0, data_ack}, 0);
      if (i >= 1) check("stall_slwr_n", {31'd0, slwr_n}, 1);
      @(posedge clk); #1;
    end
    fifo_full_n = 1'b1;
    wait_written(w0 + 6, 40, "stall_written");
    check("stall_no_dup", n_written - w0, 6);
    wait_pktend("stall_pktend");

    // A byte acked while the timer holds 1 wins over the commit.
    src_q.push_back(8'h11);
    wait_written(n_written + 1, 20, "race_first");
    l0 = last_wr_cyc;
    p0 = n_pktend;
    wait_until_cyc(l0 + 14);
    src_q.push_back(8'h22);
    @(negedge clk);
    check("race_tmr_is_1", dut.u_timer.idle_tmr, 1);
    check("race_ack", {31'd0, data_ack}, 1);
    wait_until_cyc(l0 + 17);
    check("race_written", {31'd0, slwr_n}, 0);
    check("race_tmr_reload", dut.u_timer.idle_tmr, TMO);
    wait_until_cyc(l0 + 27);
    check("race_no_pktend", n_pktend, p0);
    @(posedge clk); #1;
    wait_pktend("race_pktend");

    // A full packet back to back wraps the count with no pktend.
    pkt_allowed = 0;
    lat_check = 1;
    w0 = n_written;
    p0 = n_pktend;
    for (int i = 0; i < int'(PKT); i++) src_q.push_back(8'($urandom));
    wait_written(w0 + PKT, 2000, "full_written");
    check("full_consecutive", wr_cyc_q[w0 + PKT - 1] - wr_cyc_q[w0], PKT - 1);
    repeat (3 * TMO) @(posedge clk);
    #1;
    check("full_no_pktend", n_pktend, p0);
    check("full_state_idle", dut.state, IDLE);
    check("full_byte_cnt", dut.byte_cnt, 0);
    lat_check = 0;
    pkt_allowed = 1;

    // One-cycle reset after byte 03: held byte lost, no strobe on exit.
    w0 = n_written;
    a0 = n_acked;
    push_seq(6);
    wait_acked(a0 + 3, 40, "rst_ack3");
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_data_ack", {31'd0, data_ack}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_exit_slwr_n", {31'd0, slwr_n}, 1);
    check("rst_exit_pktend_n", {31'd0, pktend_n}, 1);
    check("rst_exit_fd", fd, 0);
    check("rst_exit_hold_valid", {31'd0, dut.hold_valid}, 0);
    check("rst_exit_byte_cnt", dut.byte_cnt, 0);
    @(posedge clk); #1;
    wait_written(w0 + 5, 40, "rst_written");
    wait_pktend("rst_pktend");
    check("rst_write_total", n_written - w0, 5);

    // Random upstream gaps and FIFO backpressure.
    pkt_allowed = 0;
    rdy_pct = 80;
    ff_rand = 1;
    w0 = n_written;
    for (int i = 0; i < 300; i++) src_q.push_back(8'($urandom));
    wait_written(w0 + 300, 5000, "rand_written");
    ff_rand = 0;
    @(posedge clk); #1;
    fifo_full_n = 1'b1;
    check("rand_byte_cnt", dut.byte_cnt, model_cnt);
    pkt_allowed = 1;
    if (model_cnt != 0) wait_pktend("rand_pktend");
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("all_acked_written", n_acked - n_written, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx2_byte_writer.md
FX2_BYTE_WRITER -- requirements
Module: fx2_byte_writer

Interface
REQ-001 Parameter PKT_BYTES, default 512: FX2 auto-commit packet size in bytes; power of two, 2..1024.
REQ-002 Parameter IDLE_TIMEOUT, default 4096: idle cycles before a partial packet is committed; range 1..65535.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 data  in  8  byte from the upstream sample serialiser; valid while data_rdy=1.
REQ-006 data_rdy  in  1  upstream byte available.
REQ-007 data_ack  out  1  byte accepted this cycle; upstream advances on each high cycle.
REQ-008 fifo_full_n  in  1  FX2 FIFO full flag, active-low (1 = space available).
REQ-009 fd  out  8  FX2 FIFO data bus, registered.
REQ-010 slwr_n  out  1  FX2 write strobe, active-low, registered.
REQ-011 pktend_n  out  1  FX2 packet-end strobe, active-low, registered.

Function
REQ-012 A one-byte holding register (hold_data, hold_valid) SHALL sit between the upstream port and the FX2 port.
REQ-013 drain SHALL be hold_valid & fifo_full_n & (state != COMMIT).
REQ-014 data_ack SHALL equal data_rdy & (~hold_valid | drain), combinationally.
REQ-015 When data_ack=1, hold_data SHALL load data at the clock edge and hold_valid SHALL become 1.
REQ-016 When drain=1 and no load occurs, hold_valid SHALL clear.
REQ-017 When drain=1, the next cycle SHALL have fd = hold_data and slwr_n = 0; otherwise slwr_n = 1 and fd holds its value.
REQ-018 Latency: a byte acked in cycle N SHALL appear with slwr_n=0 in cycle N+2 if fifo_full_n=1 in cycle N+1.
REQ-019 Sustained throughput SHALL be one byte per cycle while data_rdy=1 and fifo_full_n=1.
REQ-020 No byte SHALL be dropped or duplicated under any pattern of fifo_full_n.
REQ-021 byte_cnt, width clog2(PKT_BYTES), SHALL increment on each write and wrap from PKT_BYTES-1 to 0, with no pktend at the wrap.
REQ-022 idle_tmr (16 bits) SHALL reload to IDLE_TIMEOUT on every write and decrement each cycle while byte_cnt != 0 and no write occurs.
REQ-023 State IDLE (byte_cnt=0) SHALL go to FILL on the first write.
REQ-024 FILL SHALL go to IDLE when byte_cnt wraps to 0.
REQ-025 FILL SHALL go to COMMIT when idle_tmr reaches 0 with hold_valid=0.
REQ-026 COMMIT SHALL wait for fifo_full_n=1, then drive pktend_n=0 for exactly one cycle, clear byte_cnt and go to IDLE.
REQ-027 slwr_n and pktend_n SHALL never be low in the same cycle.
REQ-028 If a byte is loaded in the cycle idle_tmr would expire, the write SHALL win, the timer SHALL reload and no COMMIT occurs.
REQ-029 A byte arriving during COMMIT SHALL be held and written only after the pktend pulse, and then counts as byte 1 of a new packet.

Reset
REQ-030 When reset_n=0 at a clock edge: state=IDLE, hold_valid=0, byte_cnt=0, idle_tmr=IDLE_TIMEOUT, fd=8'h00, slwr_n=1, pktend_n=1.
REQ-031 While reset_n=0, data_ack SHALL be 0 regardless of data_rdy.
REQ-032 Reset mid-transfer SHALL discard the held byte and the partial-packet count; no strobe SHALL be issued during or on exit from reset.

Structure
REQ-033 State encodings (IDLE, FILL, COMMIT) and the PKT_BYTES and IDLE_TIMEOUT defaults SHALL live in the shared timetag_pkg package.
REQ-034 The idle timer with its reload/expire logic SHALL be one sub-module, commit_timer.
REQ-035 The holding register and strobe logic SHALL remain inline.

Verification
REQ-036 Reset, fifo_full_n=1, upstream sends 01 02 03 04 05 06 -> six data_ack pulses, fd 01..06 on six consecutive slwr_n=0 cycles, first strobe 2 cycles after first ack.
REQ-037 fifo_full_n=0 for 10 cycles after byte 03 is acked -> slwr_n=1 and data_ack=0 throughout; on release, bytes 03..06 written once each, in order.
REQ-038 IDLE_TIMEOUT=16, six bytes then idle -> pktend_n=0 for one cycle, 17 cycles after the last slwr_n=0 cycle; byte_cnt returns to 0.
REQ-039 512 back-to-back bytes -> 512 strobes, no pktend_n, state returns to IDLE.
REQ-040 New byte acked in the cycle idle_tmr=1 -> byte written, no pktend_n, timer reloaded to 16.
REQ-041 reset_n=0 for one cycle after byte 03 of a sample -> all outputs at reset values next cycle; no strobe for the held byte.
